// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: op codes,
// controller states and the latched multiply request.
package hilo_muldiv_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  typedef struct packed {
    op_e             op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } mul_req_t;

  function automatic logic mul_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module hilo_muldiv_ctrl_div_step
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_bit_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] shl;

  assign shl   = {rem_i, dvd_bit_i};
  assign q_o   = (shl >= {1'b0, dvs_i});
  // When the subtract succeeds the result is below the divisor, so it fits XLEN bits.
  assign rem_o = q_o ? XLEN'(shl - {1'b0, dvs_i}) : shl[XLEN-1:0];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences 2-cycle multiply(-accumulate) and 32-step restoring
// divide, stalling the pipeline while an op is in flight.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  state_e            state, state_nx;
  mul_req_t          req;
  logic [XLEN-1:0]   hi, lo;
  logic [XLEN-1:0]   rem, dq, dvs;
  logic              neg_q, neg_r;
  logic [CW-1:0]     cnt;

  logic              accept, is_mtx, is_div, is_mul, div_sgn;
  logic              msg;
  logic [2*XLEN-1:0] prod, acc, mul_res;
  logic [XLEN-1:0]   rem_nx, q_fix, r_fix;
  logic              q_bit;

  assign is_mtx  = (op_i == OP_MTHI) || (op_i == OP_MTLO);
  assign is_div  = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign is_mul  = (op_i <= 4'd7) && !is_div;
  assign div_sgn = (op_i == OP_DIV);
  assign accept  = (state == ST_IDLE) && start_i && !flush_i;

  // Sign-extending to 2*XLEN makes the truncated product correct for both signednesses.
  assign msg  = mul_signed(req.op);
  assign prod = {{XLEN{msg & req.a[XLEN-1]}}, req.a} * {{XLEN{msg & req.b[XLEN-1]}}, req.b};
  assign acc  = {hi, lo};

  always_comb begin
    mul_res = prod;
    case (req.op)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase
  end

  hilo_muldiv_ctrl_div_step u_step (
    .rem_i     (rem),
    .dvd_bit_i (dq[XLEN-1]),
    .dvs_i     (dvs),
    .rem_o     (rem_nx),
    .q_o       (q_bit)
  );

  assign q_fix = neg_q ? -dq  : dq;
  assign r_fix = neg_r ? -rem : rem;

  always_comb begin
    state_nx = state;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul) begin
          busy_o   = 1'b1;
          state_nx = ST_MUL;
        end else if (accept && is_div) begin
          busy_o   = 1'b1;
          state_nx = (b_i == '0) ? ST_DONE : ST_DIV;
        end
      end
      ST_MUL: begin
        busy_o   = !flush_i;
        state_nx = flush_i ? ST_IDLE : ST_DONE;
      end
      ST_DIV: begin
        busy_o = !flush_i;
        if (flush_i)                           state_nx = ST_IDLE;
        else if (cnt == CW'(DIV_CYCLES - 1))   state_nx = ST_FIX;
      end
      ST_FIX: begin
        busy_o   = !flush_i;
        state_nx = flush_i ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        done_o   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi    <= '0;
      lo    <= '0;
      req   <= '0;
      rem   <= '0;
      dq    <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          if (op_i == OP_MTHI) hi <= a_i;
          if (op_i == OP_MTLO) lo <= a_i;
          if (is_mul) req <= '{op: op_e'(op_i), a: a_i, b: b_i};
          if (is_div) begin
            dq    <= (div_sgn && a_i[XLEN-1]) ? -a_i : a_i;
            dvs   <= (div_sgn && b_i[XLEN-1]) ? -b_i : b_i;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= div_sgn && (a_i[XLEN-1] ^ b_i[XLEN-1]);
            neg_r <= div_sgn && a_i[XLEN-1];
          end
        end
        ST_MUL: if (!flush_i) {hi, lo} <= mul_res;
        ST_DIV: if (!flush_i) begin
          rem <= rem_nx;
          dq  <= {dq[XLEN-2:0], q_bit};
          cnt <= cnt + 1'b1;
        end
        ST_FIX: if (!flush_i) begin
          lo <= q_fix;
          hi <= r_fix;
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomised and directed checks of the HI/LO controller against a
// 64-bit arithmetic reference model.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, start_i, flush_i;
  logic [3:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi, m_lo;

  hilo_muldiv_ctrl #(.DIV_CYCLES(32)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: architectural result of one op from plain 64-bit arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, b,
                                 input logic [31:0] h, l,
                                 output logic [31:0] nh, nl);
    logic [63:0] acc, r;
    longint      sa, sb, sq, sr;
    acc = {h, l};
    nh  = h;
    nl  = l;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      OP_MULT:  begin r = 64'(sa * sb);             {nh, nl} = r; end
      OP_MULTU: begin r = {32'd0, a} * {32'd0, b};  {nh, nl} = r; end
      OP_MADD:  begin r = acc + 64'(sa * sb);       {nh, nl} = r; end
      OP_MADDU: begin r = acc + {32'd0, a} * {32'd0, b}; {nh, nl} = r; end
      OP_MSUB:  begin r = acc - 64'(sa * sb);       {nh, nl} = r; end
      OP_MSUBU: begin r = acc - {32'd0, a} * {32'd0, b}; {nh, nl} = r; end
      OP_DIV:   if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        nl = sq[31:0];
        nh = sr[31:0];
      end
      OP_DIVU:  if (b != 0) begin
        nl = a / b;
        nh = a % b;
      end
      OP_MTHI:  nh = a;
      OP_MTLO:  nl = a;
      default:  ;
    endcase
  endfunction

  // Cycles from the start edge until done_o; 0 means no done pulse at all.
  function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
    if (op == OP_MTHI || op == OP_MTLO) return 0;
    if (op == OP_DIV || op == OP_DIVU)  return (b == 0) ? 1 : 34;
    return 2;
  endfunction

  // Issue one op at cycle N and follow it cycle by cycle until back in IDLE.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b);
    logic [31:0] eh, el;
    int lat;
    ref_op(op, a, b, m_hi, m_lo, eh, el);
    lat = lat_of(op, b);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== (lat != 0)) begin
      errors++;
      $display("FAIL start_busy op=%0d: got %b want %b", op, busy_o, lat != 0);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    if (lat == 0) begin
      checks++;
      if (hi_o !== eh || lo_o !== el || done_o !== 1'b0) begin
        errors++;
        $display("FAIL mtx op=%0d: got hi=%h lo=%h done=%b want hi=%h lo=%h done=0",
                 op, hi_o, lo_o, done_o, eh, el);
      end
    end
    for (int k = 1; k <= lat; k++) begin
      checks++;
      if (done_o !== (k == lat) || busy_o !== (k != lat)) begin
        errors++;
        $display("FAIL timing op=%0d k=%0d: got done=%b busy=%b want done=%b busy=%b",
                 op, k, done_o, busy_o, k == lat, k != lat);
      end
      checks++;
      if (k == lat && (hi_o !== eh || lo_o !== el)) begin
        errors++;
        $display("FAIL result op=%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                 op, a, b, hi_o, lo_o, eh, el);
      end else if (k != lat && (hi_o !== m_hi || lo_o !== m_lo)) begin
        errors++;
        $display("FAIL early_write op=%0d k=%0d: got hi=%h lo=%h want hi=%h lo=%h",
                 op, k, hi_o, lo_o, m_hi, m_lo);
      end
      if (k < lat) begin @(posedge clk); #1; end
    end
    if (lat != 0) begin @(posedge clk); #1; end
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = 4'd0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b want all zero",
               hi_o, lo_o, busy_o, done_o);
    end
    resetn = 1'b1;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    run_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003);
    checks++;
    if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_const: got hi=%h lo=%h want ffffffff fffffffa", hi_o, lo_o);
    end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
  endtask

  task automatic test_div();
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
    checks++;
    if (lo_o !== 32'hFFFFFFFD || hi_o !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_neg: got hi=%h lo=%h want ffffffff fffffffd", hi_o, lo_o);
    end
    run_op(OP_DIVU, 32'd100, 32'd7);
    checks++;
    if (lo_o !== 32'd14 || hi_o !== 32'd2) begin
      errors++;
      $display("FAIL divu_100_7: got hi=%0d lo=%0d want 2 14", hi_o, lo_o);
    end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
  endtask

  task automatic test_macc();
    run_op(OP_MTHI, 32'd0, 32'd0);
    run_op(OP_MTLO, 32'hFFFFFFFF, 32'd0);
    run_op(OP_MADDU, 32'd1, 32'd1);
    checks++;
    if (hi_o !== 32'd1 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL maddu_carry: got hi=%h lo=%h want 1 0", hi_o, lo_o);
    end
    run_op(OP_MSUB, 32'd1, 32'd1);
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL msub_borrow: got hi=%h lo=%h want 0 ffffffff", hi_o, lo_o);
    end
    run_op(OP_MADD, 32'hFFFFFFFF, 32'd5);
    run_op(OP_MSUBU, 32'h80000000, 32'd3);
  endtask

  task automatic test_div_edge();
    run_op(OP_MTHI, 32'h11, 32'd0);
    run_op(OP_MTLO, 32'h22, 32'd0);
    run_op(OP_DIVU, 32'h1234, 32'd0);
    checks++;
    if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
      errors++;
      $display("FAIL div_zero: got hi=%h lo=%h want 11 22", hi_o, lo_o);
    end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (lo_o !== 32'h80000000 || hi_o !== 32'd0) begin
      errors++;
      $display("FAIL div_overflow: got hi=%h lo=%h want 0 80000000", hi_o, lo_o);
    end
  endtask

  // Flush after `skip` cycles of an op that takes longer than that.
  task automatic flush_after(input logic [3:0] op, input logic [31:0] a, b,
                             input int skip, input string name);
    int seen;
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (skip) @(posedge clk);
    #1;
    flush_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %b want 0", name, busy_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_o === 1'b1 || busy_o === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || hi_o !== m_hi || lo_o !== m_lo) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h activity=%0d want hi=%h lo=%h activity=0",
               name, hi_o, lo_o, seen, m_hi, m_lo);
    end
  endtask

  task automatic test_flush();
    flush_after(OP_DIV, 32'd1000, 32'd3, 10, "flush_div_iter10");
    run_op(OP_MULT, $urandom, $urandom);
    flush_after(OP_MADD, 32'd9, 32'd9, 0, "flush_mul");
    flush_after(OP_DIVU, 32'd77, 32'd5, 32, "flush_fix");
    // Start and flush together: op is dropped.
    op_i = OP_MULT; a_i = 32'd3; b_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL start_flush busy: got %b want 0", busy_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hi_o !== m_hi || lo_o !== m_lo || done_o !== 1'b0) begin
      errors++;
      $display("FAIL start_flush: got hi=%h lo=%h done=%b want hi=%h lo=%h done=0",
               hi_o, lo_o, done_o, m_hi, m_lo);
    end
  endtask

  // Flush or a held start in the DONE cycle must not disturb the committed result.
  task automatic test_done_cycle();
    logic [31:0] eh, el;
    ref_op(OP_MULTU, 32'd6, 32'd7, m_hi, m_lo, eh, el);
    op_i = OP_MULTU; a_i = 32'd6; b_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b1;
    start_i = 1'b1; op_i = OP_MTHI; a_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (done_o !== 1'b1 || hi_o !== eh || lo_o !== el) begin
      errors++;
      $display("FAIL done_flush: got done=%b hi=%h lo=%h want done=1 hi=%h lo=%h",
               done_o, hi_o, lo_o, eh, el);
    end
    flush_i = 1'b0;
    #1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++;
    if (hi_o !== eh || done_o !== 1'b0) begin
      errors++;
      $display("FAIL done_ignore_start: got hi=%h done=%b want hi=%h done=0", hi_o, done_o, eh);
    end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_mthi_reset_mid_div();
    run_op(OP_MTHI, 32'h12345678, 32'd0);
    checks++;
    if (hi_o !== 32'h12345678) begin
      errors++;
      $display("FAIL mthi: got %h want 12345678", hi_o);
    end
    run_op(OP_MTLO, 32'hCAFEF00D, 32'd0);
    op_i = OP_DIVU; a_i = 32'd50; b_i = 32'd6; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div: got hi=%h lo=%h busy=%b done=%b want all zero",
               hi_o, lo_o, busy_o, done_o);
    end
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op(OP_DIVU, 32'd50, 32'd6);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 9));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op(op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_macc();
    test_div_edge();
    test_flush();
    test_done_cycle();
    test_mthi_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multi-cycle controller for the HI/LO resource and the multiply/divide datapath. It accepts a HI/LO-class op from the EX stage and sequences either a 2-cycle signed/unsigned multiply(-accumulate) or a 32-iteration restoring divide. It owns the architectural HI/LO registers and raises a stall to the pipeline while an op is in flight. It replaces the single-cycle HI/LO path in the ALU; the ALU keeps MFHI/MFLO reads, which are fed from hi_o/lo_o.

Parameters:
DIV_CYCLES, 32, number of restoring-divide iterations; must equal the operand width.

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  asynchronous, active-low reset
start_i  in  1  EX stage presents a valid HI/LO op this cycle
op_i  in  4  op code: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO
a_i  in  32  rs operand
b_i  in  32  rt operand
flush_i  in  1  exception/flush; cancels any in-flight op
busy_o  out  1  stall request to the pipeline
done_o  out  1  one-cycle pulse: op completed, HI/LO updated
hi_o  out  32  architectural HI
lo_o  out  32  architectural LO

Behaviour:
- Reset (async, resetn=0): state=IDLE; hi_o=0; lo_o=0; busy_o=0; done_o=0. A reset mid-op abandons it with no HI/LO write.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start_i=1, flush_i=0:
  - MTHI/MTLO: write a_i to HI or LO at this edge. No busy, no done, stay IDLE.
  - Mult-class op: latch a_i, b_i and op_i, go to MUL. busy_o=1, driven combinationally in this cycle.
  - DIV/DIVU with b_i!=0: latch operands, go to DIV. busy_o=1. Iteration count is 0.
  - DIV/DIVU with b_i==0: go directly to DONE. HI/LO unchanged. busy_o=1 this cycle.
- IDLE with start_i and flush_i both high: op ignored, busy_o=0.
- MUL (1 cycle), busy_o=1:
  - Form the 64-bit product: signed for MULT/MADD/MSUB, unsigned otherwise.
  - Write at the end of the cycle:
    - MULT/MULTU: {HI,LO} = P
    - MADD/MADDU: {HI,LO} = {HI,LO} + P
    - MSUB/MSUBU: {HI,LO} = {HI,LO} - P
  - Arithmetic is modulo 2^64 and uses the HI/LO value current in the MUL cycle. Then go to DONE.
- DIV (DIV_CYCLES cycles), busy_o=1:
  - Operate on magnitudes: |a|, |b| for DIV; raw values for DIVU.
  - One restoring step per cycle: shift partial remainder left 1, subtract divisor, set quotient bit when the result is non-negative.
  - After the last iteration go to FIX.
- FIX (1 cycle), busy_o=1:
  - Sign correction for DIV: quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
  - Write LO=quotient, HI=remainder. Go to DONE.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0 (no trap).
- DONE (1 cycle): busy_o=0, done_o=1. start_i is ignored, because the EX stage still holds the consumed op. Then go to IDLE.
- Latency from the start cycle N:
  - Mult-class: HI/LO visible at N+2, done_o at N+2.
  - Divide: done_o at N+DIV_CYCLES+2 (N+34).
  - Divide by zero: done_o at N+1.
- flush_i in MUL, DIV or FIX: no HI/LO write, even in the final compute cycle. Next state is IDLE, busy_o=0 in the flush cycle. flush_i in DONE: done_o still pulses (the write is already committed).
- hi_o/lo_o always reflect the registers, with no bypass. Consumers rely on the stall for ordering.

Decomposition:
- Op encodings (4-bit) and state encodings go in the shared defines header alongside the ALU control codes.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.

Test Plan:
1. MULT a=0xFFFFFFFE, b=0x00000003 at cycle N -> busy_o high at N and N+1; at N+2 done_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
2. DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> done_o at N+34 with lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 100/7 -> lo_o=14, hi_o=2.
3. HI=0, LO=0xFFFFFFFF, MADDU a=1, b=1 -> hi_o=1, lo_o=0; then MSUB a=1, b=1 -> hi_o=0, lo_o=0xFFFFFFFF.
4. DIVU b=0 with HI=0x11, LO=0x22 -> done_o at N+1, HI/LO unchanged; DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
5. DIV started, flush_i at iteration 10 -> busy_o=0 that cycle, IDLE next, HI/LO unchanged, no done_o; a following MULT completes normally.
6. MTHI a=0x12345678 in IDLE -> hi_o=0x12345678 next cycle, busy_o never high; resetn low during DIV -> hi_o=lo_o=0, busy_o=0 immediately.
